// File: rtl/lc3b_types.sv
// Shared LC-3b type package.
//   lc3b_word      16-bit machine word / byte address
//   lc3b_line      128-bit cache line
//   arb_state_t    memory arbiter FSM states
//   LINE_ADDR_MASK clears the byte offset within a 16-byte line
package lc3b_types;

  typedef logic [15:0]  lc3b_word;
  typedef logic [127:0] lc3b_line;

  typedef enum logic [1:0] {
    IDLE,
    I_BUSY,
    D_BUSY
  } arb_state_t;

  localparam lc3b_word LINE_ADDR_MASK = 16'hFFF0;

endpackage

// File: rtl/arb_streak_ctr.sv
// Data-grant streak counter for the memory arbiter starvation guard.
// Counts data grants issued while the instruction side is waiting and
// raises force_i once the streak reaches MAX_D_STREAK.
// Ports:
//   clk, reset   clock, asynchronous active-high reset
//   i_read       instruction request level
//   grant_d      data grant issued this cycle
//   grant_i      instruction grant issued this cycle
//   force_i      instruction side must win the next arbitration
module arb_streak_ctr #(
  parameter int unsigned MAX_D_STREAK = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic i_read,
  input  logic grant_d,
  input  logic grant_i,
  output logic force_i
);

  logic [2:0] streak_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      streak_q <= 3'd0;
    end else if (grant_i) begin
      streak_q <= 3'd0;
    end else if (grant_d) begin
      if (!i_read) begin
        streak_q <= 3'd0;
      end else if (streak_q != 3'd7) begin
        streak_q <= streak_q + 3'd1;
      end
    end
  end

  assign force_i = i_read && (streak_q == 3'(MAX_D_STREAK));

endmodule

// File: rtl/mem_arbiter.sv
// Two-port cache-line arbiter sharing one memory port between the
// instruction-fetch and data-access paths. Data wins ties; the grant is held
// until pmem_resp, which is routed back to the owner in the same cycle.
// Optional starvation guard: define ARB_STARVE_GUARD_EN to let a waiting
// instruction request win after MAX_D_STREAK consecutive data grants.
// Ports:
//   clk, reset                  clock, asynchronous active-high reset
//   i_read, i_address           instruction line read request
//   i_resp, i_rdata             instruction completion pulse, returned line
//   d_read, d_write, d_address  data line request (write wins if both)
//   d_wdata                     data write line
//   d_resp, d_rdata             data completion pulse, returned line
//   pmem_read, pmem_write       memory strobes (registered state only)
//   pmem_address, pmem_wdata    latched line address / write data
//   pmem_rdata, pmem_resp       memory read line, completion
//
// state  | meaning
// IDLE   | no grant; arbitrate on request levels at the next edge
// I_BUSY | instruction side owns memory, waiting for pmem_resp
// D_BUSY | data side owns memory, waiting for pmem_resp
module mem_arbiter
  import lc3b_types::*;
#(
  parameter int unsigned MAX_D_STREAK = 4
) (
  input  logic     clk,
  input  logic     reset,
  input  logic     i_read,
  input  lc3b_word i_address,
  output logic     i_resp,
  output lc3b_line i_rdata,
  input  logic     d_read,
  input  logic     d_write,
  input  lc3b_word d_address,
  input  lc3b_line d_wdata,
  output logic     d_resp,
  output lc3b_line d_rdata,
  output logic     pmem_read,
  output logic     pmem_write,
  output lc3b_word pmem_address,
  output lc3b_line pmem_wdata,
  input  lc3b_line pmem_rdata,
  input  logic     pmem_resp
);

  // The streak counter is 3 bits wide.
  if (MAX_D_STREAK < 1 || MAX_D_STREAK > 7) begin : g_streak_range
    $error("mem_arbiter: MAX_D_STREAK must be in 1..7");
  end

  arb_state_t state_q, state_d;
  lc3b_word   addr_q;
  lc3b_line   wdata_q;
  logic       write_q;
  logic       d_req;
  logic       grant_d;
  logic       grant_i;
  logic       force_i;
  logic       busy;

  assign d_req = d_read | d_write;

`ifdef ARB_STARVE_GUARD_EN
  arb_streak_ctr #(
    .MAX_D_STREAK(MAX_D_STREAK)
  ) u_streak (
    .clk     (clk),
    .reset   (reset),
    .i_read  (i_read),
    .grant_d (grant_d),
    .grant_i (grant_i),
    .force_i (force_i)
  );
`else
  assign force_i = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      write_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (grant_d) begin
        addr_q  <= d_address;
        wdata_q <= d_wdata;
        write_q <= d_write;
      end else if (grant_i) begin
        addr_q  <= i_address;
        write_q <= 1'b0;
      end
    end
  end

  // force_i already implies i_read, so the instruction branch covers it.
  always_comb begin
    state_d = state_q;
    grant_d = 1'b0;
    grant_i = 1'b0;
    i_resp  = 1'b0;
    d_resp  = 1'b0;
    case (state_q)
      IDLE: begin
        if (d_req && !force_i) begin
          grant_d = 1'b1;
          state_d = D_BUSY;
        end else if (i_read) begin
          grant_i = 1'b1;
          state_d = I_BUSY;
        end
      end
      I_BUSY: begin
        if (pmem_resp) begin
          i_resp  = 1'b1;
          state_d = IDLE;
        end
      end
      D_BUSY: begin
        if (pmem_resp) begin
          d_resp  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy         = (state_q != IDLE);
  assign pmem_read    = busy & ~write_q;
  assign pmem_write   = busy & write_q;
  assign pmem_address = addr_q & LINE_ADDR_MASK;
  assign pmem_wdata   = wdata_q;
  assign i_rdata      = pmem_rdata;
  assign d_rdata      = pmem_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

  localparam int unsigned MAX_STREAK = 2;
`ifdef ARB_STARVE_GUARD_EN
  localparam bit GUARD_EN = 1'b1;
`else
  localparam bit GUARD_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         i_read = 1'b0;
  logic [15:0]  i_address = '0;
  logic         i_resp;
  logic [127:0] i_rdata;
  logic         d_read = 1'b0;
  logic         d_write = 1'b0;
  logic [15:0]  d_address = '0;
  logic [127:0] d_wdata = '0;
  logic         d_resp;
  logic [127:0] d_rdata;
  logic         pmem_read;
  logic         pmem_write;
  logic [15:0]  pmem_address;
  logic [127:0] pmem_wdata;
  logic [127:0] pmem_rdata = '0;
  logic         pmem_resp = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  mem_arbiter #(.MAX_D_STREAK(MAX_STREAK)) dut (
    .clk          (clk),
    .reset        (reset),
    .i_read       (i_read),
    .i_address    (i_address),
    .i_resp       (i_resp),
    .i_rdata      (i_rdata),
    .d_read       (d_read),
    .d_write      (d_write),
    .d_address    (d_address),
    .d_wdata      (d_wdata),
    .d_resp       (d_resp),
    .d_rdata      (d_rdata),
    .pmem_read    (pmem_read),
    .pmem_write   (pmem_write),
    .pmem_address (pmem_address),
    .pmem_wdata   (pmem_wdata),
    .pmem_rdata   (pmem_rdata),
    .pmem_resp    (pmem_resp)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish (n_fail=%0d)", n_fail);
    $fatal(1, "watchdog");
  end

  typedef struct {
    bit           is_d;
    bit           wr;
    logic [15:0]  addr;
    logic [127:0] wdata;
    logic [127:0] rdata;
    int           lat;
    logic [15:0]  exp_addr;
  } vec_t;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    i_read = 0; d_read = 0; d_write = 0; pmem_resp = 0;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    tick();
  endtask

  // One complete transaction from IDLE; memory answers after v.lat extra busy cycles.
  task automatic run_txn(input vec_t v, input int idx);
    string tag;
    tag = $sformatf("vec%0d", idx);
    pmem_resp = 0;
    if (v.is_d) begin
      d_read = !v.wr; d_write = v.wr; d_address = v.addr; d_wdata = v.wdata;
    end else begin
      i_read = 1; i_address = v.addr;
    end
    @(negedge clk);
    chk({tag, "_req_cycle_strobes"}, {pmem_read, pmem_write}, 2'b00);
    for (int k = 0; k <= v.lat; k++) begin
      tick();
      if (k == v.lat) begin
        pmem_resp = 1; pmem_rdata = v.rdata;
      end
      @(negedge clk);
      chk({tag, "_pmem_read"}, pmem_read, !v.wr);
      chk({tag, "_pmem_write"}, pmem_write, v.wr);
      chk({tag, "_pmem_address"}, pmem_address, v.exp_addr);
      if (v.is_d && v.wr) chk({tag, "_pmem_wdata"}, pmem_wdata, v.wdata);
      chk({tag, "_own_resp"}, v.is_d ? d_resp : i_resp, k == v.lat);
      chk({tag, "_other_resp"}, v.is_d ? i_resp : d_resp, 1'b0);
      if (k == v.lat) chk({tag, "_rdata"}, v.is_d ? d_rdata : i_rdata, v.rdata);
    end
    tick();
    clear_inputs();
    @(negedge clk);
    chk({tag, "_bubble_strobes"}, {pmem_read, pmem_write}, 2'b00);
    tick();
  endtask

  // Waits (bounded) for a grant, answers it at once, reports who got the resp (1=I, 2=D).
  task automatic serve_one(input bit drop_d_after, output int who);
    bit found;
    found = 0;
    who = 0;
    for (int c = 0; c < 6 && !found; c++) begin
      @(negedge clk);
      if (pmem_read || pmem_write) found = 1;
    end
    if (!found) begin
      chk("streak_grant_timeout", {pmem_read, pmem_write} != 2'b00, 1'b1);
      return;
    end
    pmem_resp = 1;
    #1;
    if (d_resp && !i_resp) who = 2;
    else if (i_resp && !d_resp) who = 1;
    else who = 3;
    tick();
    pmem_resp = 0;
    if (who == 1) i_read = 0;
    if (who == 2 && drop_d_after) d_read = 0;
  endtask

  vec_t vecs[6];

  // Reference model of the outstanding transaction for the random phase.
  bit           g_valid;
  int           g_who;
  logic [15:0]  g_addr;
  bit           g_write;
  logic [127:0] g_wdata;
  int           g_lat;
  int           g_cnt;
  bit           i_act, d_act, d_wr, resp_now, force_i_m;
  int           streak;

  initial begin
    int who;
    int exp_order[4];
    vecs[0] = '{1'b1, 1'b0, 16'h1236, 128'h0, 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210, 3, 16'h1230};
    vecs[1] = '{1'b1, 1'b1, 16'hFFFF, 128'hDEAD_BEEF_0000_1111_2222_3333_4444_5555, 128'h0, 0, 16'hFFF0};
    vecs[2] = '{1'b0, 1'b0, 16'h0040, 128'h0, 128'hAAAA_5555_AAAA_5555_AAAA_5555_AAAA_5555, 1, 16'h0040};
    vecs[3] = '{1'b0, 1'b0, 16'h000F, 128'h0, 128'h1, 2, 16'h0000};
    vecs[4] = '{1'b1, 1'b1, 16'h8008, 128'hCAFE_F00D_CAFE_F00D_CAFE_F00D_CAFE_F00D, 128'h0, 2, 16'h8000};
    vecs[5] = '{1'b1, 1'b0, 16'hABCD, 128'h0, 128'hFFFF_0000_FFFF_0000_FFFF_0000_FFFF_0000, 0, 16'hABC0};

    // Reset state
    #12;
    chk("rst_pmem_read", pmem_read, 1'b0);
    chk("rst_pmem_write", pmem_write, 1'b0);
    chk("rst_pmem_address", pmem_address, 16'h0000);
    chk("rst_pmem_wdata", pmem_wdata, 128'h0);
    chk("rst_resps", {i_resp, d_resp}, 2'b00);
    #10 reset = 1'b0;
    tick();

    for (int n = 0; n < 6; n++) run_txn(vecs[n], n);

    // Simultaneous requests: data first, one bubble, then instruction.
    i_read = 1; i_address = 16'h0100;
    d_write = 1; d_address = 16'h0207; d_wdata = 128'h5A5A;
    tick();
    pmem_resp = 1;
    @(negedge clk);
    chk("sim_d_write", {pmem_read, pmem_write}, 2'b01);
    chk("sim_d_addr", pmem_address, 16'h0200);
    chk("sim_d_resp", {i_resp, d_resp}, 2'b01);
    tick();
    pmem_resp = 0; d_write = 0;
    @(negedge clk);
    chk("sim_bubble", {pmem_read, pmem_write}, 2'b00);
    tick();
    @(negedge clk);
    chk("sim_i_read", {pmem_read, pmem_write}, 2'b10);
    chk("sim_i_addr", pmem_address, 16'h0100);
    pmem_resp = 1;
    #1;
    chk("sim_i_resp", {i_resp, d_resp}, 2'b10);
    tick();
    clear_inputs();
    tick();

    // Address latch: instruction address changes mid-service.
    i_read = 1; i_address = 16'h0040;
    tick();
    @(negedge clk);
    chk("latch_addr_0", pmem_address, 16'h0040);
    i_address = 16'h0080;
    tick();
    @(negedge clk);
    chk("latch_addr_1", pmem_address, 16'h0040);
    tick();
    pmem_resp = 1;
    @(negedge clk);
    chk("latch_addr_2", pmem_address, 16'h0040);
    chk("latch_i_resp", i_resp, 1'b1);
    tick();
    clear_inputs();
    tick();

    // Stray resp in IDLE
    pmem_resp = 1;
    @(negedge clk);
    chk("stray_resps", {i_resp, d_resp}, 2'b00);
    chk("stray_strobes", {pmem_read, pmem_write}, 2'b00);
    tick();
    pmem_resp = 0;
    @(negedge clk);
    chk("stray_still_idle", {pmem_read, pmem_write}, 2'b00);
    tick();

    // Reset mid-service
    d_read = 1; d_address = 16'h3333;
    tick();
    @(negedge clk);
    chk("rstmid_busy", pmem_read, 1'b1);
    #2 reset = 1'b1;
    #1;
    chk("rstmid_strobes", {pmem_read, pmem_write}, 2'b00);
    chk("rstmid_addr", pmem_address, 16'h0000);
    d_read = 0;
    @(negedge clk);
    reset = 1'b0;
    tick();
    run_txn(vecs[2], 10);

    // Streak: instruction held, data requests back-to-back.
    do_reset();
    exp_order = GUARD_EN ? '{2, 2, 1, 2} : '{2, 2, 2, 2};
    i_read = 1; i_address = 16'h0440;
    d_read = 1; d_address = 16'h0880;
    for (int g = 0; g < 4; g++) begin
      serve_one(g == 3, who);
      chk($sformatf("streak_grant%0d", g), who, exp_order[g]);
    end
    do_reset();

    // Random phase against the transaction-level model.
    g_valid = 0; i_act = 0; d_act = 0; d_wr = 0; streak = 0;
    g_who = 0; g_addr = '0; g_write = 0; g_wdata = '0; g_lat = 0; g_cnt = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (!i_act && $urandom_range(0, 2) == 0) i_act = 1;
      if (!d_act && $urandom_range(0, 2) == 0) begin
        d_act = 1; d_wr = 1'($urandom_range(0, 1));
      end
      i_read = i_act; d_read = d_act && !d_wr; d_write = d_act && d_wr;
      i_address = 16'($urandom); d_address = 16'($urandom);
      d_wdata = {$urandom, $urandom, $urandom, $urandom};
      pmem_rdata = {$urandom, $urandom, $urandom, $urandom};
      resp_now = g_valid ? (g_cnt == g_lat) : ($urandom_range(0, 7) == 0);
      pmem_resp = resp_now;
      @(negedge clk);
      chk("rnd_pmem_read", pmem_read, g_valid && !g_write);
      chk("rnd_pmem_write", pmem_write, g_valid && g_write);
      if (g_valid) chk("rnd_pmem_address", pmem_address, {g_addr[15:4], 4'h0});
      if (g_valid && g_write) chk("rnd_pmem_wdata", pmem_wdata, g_wdata);
      chk("rnd_i_resp", i_resp, g_valid && g_who == 1 && resp_now);
      chk("rnd_d_resp", d_resp, g_valid && g_who == 2 && resp_now);
      chk("rnd_i_rdata", i_rdata, pmem_rdata);
      chk("rnd_d_rdata", d_rdata, pmem_rdata);
      @(posedge clk);
      if (g_valid) begin
        if (g_cnt == g_lat) begin
          g_valid = 0;
          if (g_who == 1) i_act = 0; else d_act = 0;
        end else begin
          g_cnt++;
        end
      end else begin
        force_i_m = GUARD_EN && (streak == int'(MAX_STREAK)) && i_act;
        if (d_act && !force_i_m) begin
          g_valid = 1; g_who = 2; g_addr = d_address; g_write = d_wr; g_wdata = d_wdata;
          streak = i_act ? ((streak < 7) ? streak + 1 : 7) : 0;
        end else if (i_act) begin
          g_valid = 1; g_who = 1; g_addr = i_address; g_write = 0;
          streak = 0;
        end
        g_cnt = 0;
        g_lat = $urandom_range(0, 3);
      end
      #1;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
